// File: rtl/mor1kx_marocchino_pkg.sv
// rtl/mor1kx_marocchino_pkg.sv - shared widths, OCB entry layout and exception bit indices
package mor1kx_marocchino_pkg;

    localparam int DEF_OPERAND_WIDTH = 32;
    localparam int DEF_RF_ADDR_WIDTH = 5;
    localparam int DEF_NUM_UNITS     = 4;
    localparam int DEF_OCB_DEPTH     = 4;

    function automatic int uid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int UID_W     = uid_w(DEF_NUM_UNITS);
    localparam int OCB_PTR_W = $clog2(DEF_OCB_DEPTH);
    localparam int OCB_CNT_W = OCB_PTR_W + 1;

    // Entry packing, LSB first: delay_slot, pc, rf_wb, rfd_adr, unit
    localparam int OCB_DS_POS = 0;
    localparam int OCB_PC_LSB = 1;

    function automatic int ocb_rfwb_pos(input int ow);
        return ow + 1;
    endfunction

    function automatic int ocb_rfd_lsb(input int ow);
        return ow + 2;
    endfunction

    function automatic int ocb_unit_lsb(input int ow, input int aw);
        return ow + 2 + aw;
    endfunction

    function automatic int ocb_entry_w(input int ow, input int aw, input int uw);
        return ow + 2 + aw + uw;
    endfunction

    localparam int EXCEPT_IBUS_ERR   = 0;
    localparam int EXCEPT_ITLB_MISS  = 1;
    localparam int EXCEPT_IPAGEFAULT = 2;
    localparam int EXCEPT_IBUS_ALIGN = 3;
    localparam int EXCEPT_ILLEGAL    = 4;
    localparam int EXCEPT_SYSCALL    = 5;
    localparam int EXCEPT_DBUS_ERR   = 6;
    localparam int EXCEPT_DTLB_MISS  = 7;
    localparam int EXCEPT_DPAGEFAULT = 8;
    localparam int EXCEPT_TRAP       = 9;
    localparam int EXCEPT_DBUS_ALIGN = 10;

endpackage

// File: rtl/mor1kx_ocb_marocchino.sv
// rtl/mor1kx_ocb_marocchino.sv - order control buffer: in-order FIFO of issued instructions
module mor1kx_ocb_marocchino #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] entry_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Guarded again here so the buffer stays consistent whatever the caller does
    assign push_ok = push_i & ~full_o & ~flush_i;
    assign pop_ok  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= entry_i;
    end

endmodule

// File: rtl/mor1kx_wb_arbiter_marocchino.sv
// rtl/mor1kx_wb_arbiter_marocchino.sv - in-order multi-unit write-back arbiter for MAROCCHINO
module mor1kx_wb_arbiter_marocchino
    import mor1kx_marocchino_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5,
    parameter int NUM_UNITS            = 4,
    parameter int OCB_DEPTH            = 4,
    parameter int EXCEPT_WIDTH         = 11,
    localparam int UNIT_W              = uid_w(NUM_UNITS)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   pipeline_flush_i,
    input  logic                                   wb_stall_i,
    input  logic                                   dcod_valid_i,
    input  logic [UNIT_W-1:0]                      dcod_unit_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0]        dcod_rfd_adr_i,
    input  logic                                   dcod_rf_wb_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]        dcod_pc_i,
    input  logic                                   dcod_delay_slot_i,
    output logic                                   ocb_full_o,
    output logic                                   ocb_empty_o,
    input  logic [NUM_UNITS-1:0]                   unit_rdy_i,
    input  logic [NUM_UNITS*OPTION_OPERAND_WIDTH-1:0] unit_result_i,
    input  logic [NUM_UNITS-1:0]                   unit_flag_set_i,
    input  logic [NUM_UNITS-1:0]                   unit_flag_clear_i,
    input  logic [NUM_UNITS*EXCEPT_WIDTH-1:0]      unit_except_i,
    output logic [NUM_UNITS-1:0]                   unit_taken_o,
    input  logic                                   ctrl_mfspr_rdy_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]        mfspr_dat_i,
    output logic                                   wb_valid_o,
    output logic                                   wb_rf_wb_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0]        wb_rfd_adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]        wb_result_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]        pc_wb_o,
    output logic                                   wb_delay_slot_o,
    output logic                                   wb_flag_set_o,
    output logic                                   wb_flag_clear_o,
    output logic [EXCEPT_WIDTH-1:0]                wb_except_o,
    output logic                                   wb_excepts_en_o
);

    localparam int OW       = OPTION_OPERAND_WIDTH;
    localparam int AW       = OPTION_RF_ADDR_WIDTH;
    localparam int ENT_W    = ocb_entry_w(OW, AW, UNIT_W);
    localparam int RFWB_POS = ocb_rfwb_pos(OW);
    localparam int RFD_LSB  = ocb_rfd_lsb(OW);
    localparam int UNIT_LSB = ocb_unit_lsb(OW, AW);

    logic [ENT_W-1:0]        entry_in, head_entry;
    logic                    push, commit;
    logic [UNIT_W-1:0]       head_unit;
    logic [AW-1:0]           head_rfd;
    logic                    head_rf_wb, head_ds;
    logic [OW-1:0]           head_pc;
    logic [NUM_UNITS-1:0]    head_oh;
    logic                    head_rdy, head_fs, head_fc;
    logic [OW-1:0]           head_result;
    logic [EXCEPT_WIDTH-1:0] head_exc;

    logic                    wb_valid_q, wb_valid_d;
    logic                    wb_rf_wb_q, wb_rf_wb_d;
    logic [AW-1:0]           wb_rfd_adr_q, wb_rfd_adr_d;
    logic [OW-1:0]           wb_result_q, wb_result_d;
    logic [OW-1:0]           pc_wb_q, pc_wb_d;
    logic                    wb_delay_slot_q, wb_delay_slot_d;
    logic                    wb_flag_set_q, wb_flag_set_d;
    logic                    wb_flag_clear_q, wb_flag_clear_d;
    logic [EXCEPT_WIDTH-1:0] wb_except_q, wb_except_d;
    logic                    wb_excepts_en_q, wb_excepts_en_d;

    assign entry_in = {dcod_unit_i, dcod_rfd_adr_i, dcod_rf_wb_i, dcod_pc_i, dcod_delay_slot_i};
    assign push     = dcod_valid_i & ~ocb_full_o & ~pipeline_flush_i;

    mor1kx_ocb_marocchino #(
        .DEPTH (OCB_DEPTH),
        .WIDTH (ENT_W)
    ) u_ocb (
        .clk     (clk),
        .rst     (rst),
        .flush_i (pipeline_flush_i),
        .push_i  (push),
        .pop_i   (commit),
        .entry_i (entry_in),
        .head_o  (head_entry),
        .full_o  (ocb_full_o),
        .empty_o (ocb_empty_o)
    );

    assign head_ds    = head_entry[OCB_DS_POS];
    assign head_pc    = head_entry[OCB_PC_LSB +: OW];
    assign head_rf_wb = head_entry[RFWB_POS];
    assign head_rfd   = head_entry[RFD_LSB +: AW];
    assign head_unit  = head_entry[UNIT_LSB +: UNIT_W];

    // An out-of-range unit index matches no slice, so that entry never becomes ready
    always_comb begin
        head_oh     = '0;
        head_rdy    = 1'b0;
        head_fs     = 1'b0;
        head_fc     = 1'b0;
        head_result = '0;
        head_exc    = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (head_unit == UNIT_W'(k)) begin
                head_oh[k]  = 1'b1;
                head_rdy    = unit_rdy_i[k];
                head_fs     = unit_flag_set_i[k];
                head_fc     = unit_flag_clear_i[k];
                head_result = unit_result_i[k*OW +: OW];
                head_exc    = unit_except_i[k*EXCEPT_WIDTH +: EXCEPT_WIDTH];
            end
        end
    end

    assign commit       = ~ocb_empty_o & head_rdy & ~wb_stall_i & ~pipeline_flush_i;
    assign unit_taken_o = commit ? head_oh : '0;

    always_comb begin
        wb_valid_d      = commit;
        wb_rf_wb_d      = commit & head_rf_wb & ~(|head_exc);
        wb_flag_set_d   = commit & head_fs;
        wb_flag_clear_d = commit & head_fc;
        wb_except_d     = commit ? head_exc : '0;
        wb_excepts_en_d = commit & (|head_exc);
        wb_rfd_adr_d    = commit ? head_rfd : wb_rfd_adr_q;
        pc_wb_d         = commit ? head_pc : pc_wb_q;
        wb_result_d     = commit ? head_result : wb_result_q;
        wb_delay_slot_d = pipeline_flush_i ? 1'b0 : (commit ? head_ds : wb_delay_slot_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q      <= 1'b0;
            wb_rf_wb_q      <= 1'b0;
            wb_rfd_adr_q    <= '0;
            wb_result_q     <= '0;
            pc_wb_q         <= '0;
            wb_delay_slot_q <= 1'b0;
            wb_flag_set_q   <= 1'b0;
            wb_flag_clear_q <= 1'b0;
            wb_except_q     <= '0;
            wb_excepts_en_q <= 1'b0;
        end else begin
            wb_valid_q      <= wb_valid_d;
            wb_rf_wb_q      <= wb_rf_wb_d;
            wb_rfd_adr_q    <= wb_rfd_adr_d;
            wb_result_q     <= wb_result_d;
            pc_wb_q         <= pc_wb_d;
            wb_delay_slot_q <= wb_delay_slot_d;
            wb_flag_set_q   <= wb_flag_set_d;
            wb_flag_clear_q <= wb_flag_clear_d;
            wb_except_q     <= wb_except_d;
            wb_excepts_en_q <= wb_excepts_en_d;
        end
    end

    assign wb_valid_o      = wb_valid_q;
    assign wb_rf_wb_o      = wb_rf_wb_q;
    assign wb_rfd_adr_o    = wb_rfd_adr_q;
    assign pc_wb_o         = pc_wb_q;
    assign wb_delay_slot_o = wb_delay_slot_q;
    assign wb_flag_set_o   = wb_flag_set_q;
    assign wb_flag_clear_o = wb_flag_clear_q;
    assign wb_except_o     = wb_except_q;
    assign wb_excepts_en_o = wb_excepts_en_q;
    assign wb_result_o     = ctrl_mfspr_rdy_i ? mfspr_dat_i : wb_result_q;

endmodule

// File: tb/tb_mor1kx_wb_arbiter_marocchino.sv
// tb/tb_mor1kx_wb_arbiter_marocchino.sv - scoreboard bench for the write-back arbiter
module tb_mor1kx_wb_arbiter_marocchino;

    localparam int NU = 4;
    localparam int OW = 32;
    localparam int EW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          pipeline_flush, wb_stall;
    logic          dcod_valid;
    logic [1:0]    dcod_unit;
    logic [4:0]    dcod_rfd_adr;
    logic          dcod_rf_wb;
    logic [31:0]   dcod_pc;
    logic          dcod_delay_slot;
    logic          ocb_full, ocb_empty;
    logic [NU-1:0] unit_rdy, unit_flag_set, unit_flag_clear, unit_taken;
    logic [NU*OW-1:0] unit_result;
    logic [NU*EW-1:0] unit_except;
    logic          ctrl_mfspr_rdy;
    logic [31:0]   mfspr_dat;
    logic          wb_valid, wb_rf_wb, wb_delay_slot, wb_flag_set, wb_flag_clear, wb_excepts_en;
    logic [4:0]    wb_rfd_adr;
    logic [31:0]   wb_result, pc_wb;
    logic [EW-1:0] wb_except;

    mor1kx_wb_arbiter_marocchino dut (
        .clk               (clk),
        .rst               (rst),
        .pipeline_flush_i  (pipeline_flush),
        .wb_stall_i        (wb_stall),
        .dcod_valid_i      (dcod_valid),
        .dcod_unit_i       (dcod_unit),
        .dcod_rfd_adr_i    (dcod_rfd_adr),
        .dcod_rf_wb_i      (dcod_rf_wb),
        .dcod_pc_i         (dcod_pc),
        .dcod_delay_slot_i (dcod_delay_slot),
        .ocb_full_o        (ocb_full),
        .ocb_empty_o       (ocb_empty),
        .unit_rdy_i        (unit_rdy),
        .unit_result_i     (unit_result),
        .unit_flag_set_i   (unit_flag_set),
        .unit_flag_clear_i (unit_flag_clear),
        .unit_except_i     (unit_except),
        .unit_taken_o      (unit_taken),
        .ctrl_mfspr_rdy_i  (ctrl_mfspr_rdy),
        .mfspr_dat_i       (mfspr_dat),
        .wb_valid_o        (wb_valid),
        .wb_rf_wb_o        (wb_rf_wb),
        .wb_rfd_adr_o      (wb_rfd_adr),
        .wb_result_o       (wb_result),
        .pc_wb_o           (pc_wb),
        .wb_delay_slot_o   (wb_delay_slot),
        .wb_flag_set_o     (wb_flag_set),
        .wb_flag_clear_o   (wb_flag_clear),
        .wb_except_o       (wb_except),
        .wb_excepts_en_o   (wb_excepts_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   pc;
        logic [4:0]    rd;
        logic          rf_wb;
        logic          ds;
        logic [31:0]   res;
        logic [EW-1:0] exc;
        logic          fs;
        logic          fc;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_errors = 0;
    logic [NU-1:0] taken_seen;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Commit monitor: every registered commit pulse must match the oldest outstanding issue
    always @(negedge clk) begin
        if (!rst && wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_commit", 64'(pc_wb), 64'hffff_ffff_ffff_ffff);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_pc",     64'(pc_wb),         64'(e.pc));
                chk("sb_rd",     64'(wb_rfd_adr),    64'(e.rd));
                chk("sb_rf_wb",  64'(wb_rf_wb),      64'(e.rf_wb & ~(|e.exc)));
                chk("sb_ds",     64'(wb_delay_slot), 64'(e.ds));
                chk("sb_result", 64'(wb_result),     64'(e.res));
                chk("sb_except", 64'(wb_except),     64'(e.exc));
                chk("sb_exc_en", 64'(wb_excepts_en), 64'(|e.exc));
                chk("sb_fs",     64'(wb_flag_set),   64'(e.fs));
                chk("sb_fc",     64'(wb_flag_clear), 64'(e.fc));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        taken_seen = unit_taken;
        @(posedge clk);
        #1;
        unit_rdy   = unit_rdy & ~taken_seen;
        dcod_valid = 1'b0;
    endtask

    task automatic set_unit(input int u, input logic [31:0] res, input logic [EW-1:0] exc,
                            input logic fs, input logic fc);
        unit_rdy[u]              = 1'b1;
        unit_result[u*OW +: OW]  = res;
        unit_except[u*EW +: EW]  = exc;
        unit_flag_set[u]         = fs;
        unit_flag_clear[u]       = fc;
    endtask

    task automatic issue(input int u, input logic [4:0] rd, input logic rf_wb, input logic [31:0] pc,
                         input logic ds, input logic [31:0] res, input logic [EW-1:0] exc,
                         input logic fs, input logic rdy_now, input logic accept);
        exp_t e;
        assert (u < NU) else $fatal(1, "FAIL illegal_unit: got %0d expected < %0d", u, NU);
        dcod_valid      = 1'b1;
        dcod_unit       = 2'(u);
        dcod_rfd_adr    = rd;
        dcod_rf_wb      = rf_wb;
        dcod_pc         = pc;
        dcod_delay_slot = ds;
        if (rdy_now) set_unit(u, res, exc, fs, 1'b0);
        if (accept) begin
            e.pc = pc; e.rd = rd; e.rf_wb = rf_wb; e.ds = ds;
            e.res = res; e.exc = exc; e.fs = fs; e.fc = 1'b0;
            sb.push_back(e);
        end
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; pipeline_flush = 1'b0; wb_stall = 1'b0;
        dcod_valid = 1'b0; dcod_unit = '0; dcod_rfd_adr = '0; dcod_rf_wb = 1'b0;
        dcod_pc = '0; dcod_delay_slot = 1'b0;
        unit_rdy = '0; unit_result = '0; unit_flag_set = '0; unit_flag_clear = '0; unit_except = '0;
        ctrl_mfspr_rdy = 1'b0; mfspr_dat = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", 64'(ocb_empty), 64'd1);
        chk("rst_full",  64'(ocb_full),  64'd0);
        chk("rst_valid", 64'(wb_valid),  64'd0);
        chk("rst_pc",    64'(pc_wb),     64'd0);
        chk("rst_result", 64'(wb_result), 64'd0);
        chk("rst_taken", 64'(unit_taken), 64'd0);
        rst = 1'b0;

        // basic commit: unit 2, r5, pc 0x100
        issue(2, 5'd5, 1'b1, 32'h100, 1'b0, 32'hDEADBEEF, '0, 1'b0, 1'b0, 1'b1);
        set_unit(2, 32'hDEADBEEF, '0, 1'b0, 1'b0);
        step();
        chk("t1_taken", 64'(taken_seen), 64'b0100);
        chk("t1_valid", 64'(wb_valid),   64'd1);
        chk("t1_rd",    64'(wb_rfd_adr), 64'd5);
        chk("t1_pc",    64'(pc_wb),      64'h100);
        step();
        chk("t1_pulse", 64'(wb_valid),   64'd0);
        chk("t1_hold",  64'(pc_wb),      64'h100);

        // out-of-order completion is committed in program order
        issue(1, 5'd1, 1'b1, 32'h10, 1'b0, 32'h11, '0, 1'b0, 1'b0, 1'b1);
        issue(0, 5'd2, 1'b1, 32'h14, 1'b1, 32'h22, '0, 1'b0, 1'b0, 1'b1);
        set_unit(0, 32'h22, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_no_taken", 64'(taken_seen), 64'd0);
        end
        set_unit(1, 32'h11, '0, 1'b0, 1'b0);
        step();
        chk("t2_taken1", 64'(taken_seen), 64'b0010);
        step();
        chk("t2_taken0", 64'(taken_seen), 64'b0001);
        step();

        // fill to full, drop a fifth issue, drain
        for (int i = 0; i < 4; i++)
            issue(i, 5'(8 + i), 1'b1, 32'h200 + 32'(4 * i), 1'b0, 32'h1000 + 32'(i), '0, 1'b0, 1'b0, 1'b1);
        chk("t3_full", 64'(ocb_full), 64'd1);
        issue(0, 5'd31, 1'b1, 32'h210, 1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0);
        chk("t3_still_full", 64'(ocb_full), 64'd1);
        for (int i = 0; i < 4; i++) set_unit(i, 32'h1000 + 32'(i), '0, 1'b0, 1'b0);
        repeat (5) step();
        chk("t3_drained", 64'(ocb_empty), 64'd1);

        // six entries streamed through the buffer, crossing the pointer wrap
        for (int i = 0; i < 6; i++)
            issue(i % 4, 5'(16 + i), 1'b1, 32'h300 + 32'(4 * i), 1'(i % 2), 32'h3000 + 32'(i), '0,
                  1'b0, 1'b1, 1'b1);
        repeat (2) step();
        chk("t3_wrap_empty", 64'(ocb_empty), 64'd1);

        // exception suppresses the RF write
        issue(3, 5'd7, 1'b1, 32'h400, 1'b1, 32'h77, 11'h004, 1'b1, 1'b0, 1'b1);
        set_unit(3, 32'h77, 11'h004, 1'b1, 1'b0);
        step();
        chk("t4_except", 64'(wb_except),     64'h004);
        chk("t4_exc_en", 64'(wb_excepts_en), 64'd1);
        chk("t4_rf_wb",  64'(wb_rf_wb),      64'd0);
        step();

        // flush with three entries, head ready and a new issue in the same cycle
        for (int i = 0; i < 3; i++)
            issue(i, 5'(20 + i), 1'b1, 32'h500 + 32'(4 * i), 1'b1, 32'h5000, '0, 1'b0, 1'b0, 1'b0);
        set_unit(0, 32'h5000, '0, 1'b0, 1'b0);
        pipeline_flush = 1'b1;
        issue(1, 5'd23, 1'b1, 32'h50C, 1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0);
        pipeline_flush = 1'b0;
        unit_rdy = '0;
        chk("t5_taken",  64'(taken_seen),    64'd0);
        chk("t5_empty",  64'(ocb_empty),     64'd1);
        chk("t5_valid",  64'(wb_valid),      64'd0);
        chk("t5_rf_wb",  64'(wb_rf_wb),      64'd0);
        chk("t5_except", 64'(wb_except),     64'd0);
        chk("t5_ds",     64'(wb_delay_slot), 64'd0);
        chk("t5_flags",  64'({wb_flag_set, wb_flag_clear, wb_excepts_en}), 64'd0);

        // stall holds off the commit; MFSPR overrides the result combinationally
        issue(2, 5'd9, 1'b1, 32'h600, 1'b0, 32'hABCD, '0, 1'b0, 1'b0, 1'b1);
        wb_stall = 1'b1;
        set_unit(2, 32'hABCD, '0, 1'b0, 1'b0);
        step();
        chk("t6_stall0", 64'(taken_seen), 64'd0);
        step();
        chk("t6_stall1", 64'(taken_seen), 64'd0);
        wb_stall = 1'b0;
        step();
        chk("t6_taken", 64'(taken_seen), 64'b0100);
        chk("t6_valid", 64'(wb_valid),   64'd1);
        step();
        ctrl_mfspr_rdy = 1'b1;
        mfspr_dat = 32'h55;
        #1;
        chk("t6_mfspr", 64'(wb_result), 64'h55);
        ctrl_mfspr_rdy = 1'b0;
        #1;
        chk("t6_result_hold", 64'(wb_result), 64'hABCD);
        step();

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mor1kx_wb_arbiter_marocchino.md
Name: mor1kx_wb_arbiter_marocchino

Overview:
- Parametrised write-back stage for MAROCCHINO with NUM_UNITS result-producing execution units (ALU, LSU, MUL, DIV, FPU, ...).
- An order control buffer (OCB) records issued instructions in program order. The block commits the head entry once its owning unit reports ready, and registers the RF write, flags and exceptions for the CTRL stage.
- Replaces the fixed ALU/LSU write-back mux with in-order multi-unit arbitration and flush handling.

Parameters:
- OPTION_OPERAND_WIDTH, 32, result/PC width
- OPTION_RF_ADDR_WIDTH, 5, register-file address width
- NUM_UNITS, 4, number of execution units (>=2)
- OCB_DEPTH, 4, OCB entries (power of 2, >=2)
- EXCEPT_WIDTH, 11, per-instruction exception vector width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pipeline_flush_i  in  1  flush all in-flight state
- wb_stall_i  in  1  CTRL cannot accept a commit this cycle
- dcod_valid_i  in  1  instruction issued this cycle
- dcod_unit_i  in  UID_W  owning unit index; UID_W = max(1, clog2(NUM_UNITS))
- dcod_rfd_adr_i  in  OPTION_RF_ADDR_WIDTH  destination register
- dcod_rf_wb_i  in  1  instruction writes the RF
- dcod_pc_i  in  OPTION_OPERAND_WIDTH  instruction PC
- dcod_delay_slot_i  in  1  instruction is in a delay slot
- ocb_full_o  out  1  OCB full; decode must stall
- ocb_empty_o  out  1  OCB empty
- unit_rdy_i  in  NUM_UNITS  unit result valid
- unit_result_i  in  NUM_UNITS*OPTION_OPERAND_WIDTH  unit results, unit k at slice k
- unit_flag_set_i, unit_flag_clear_i  in  NUM_UNITS each  flag updates
- unit_except_i  in  NUM_UNITS*EXCEPT_WIDTH  unit exception vectors
- unit_taken_o  out  NUM_UNITS  one-hot commit acknowledge
- ctrl_mfspr_rdy_i  in  1  MFSPR data override
- mfspr_dat_i  in  OPTION_OPERAND_WIDTH  MFSPR data
- wb_valid_o  out  1  commit pulse
- wb_rf_wb_o  out  1  RF write strobe
- wb_rfd_adr_o  out  OPTION_RF_ADDR_WIDTH  destination register
- wb_result_o  out  OPTION_OPERAND_WIDTH  result
- pc_wb_o  out  OPTION_OPERAND_WIDTH  committed PC
- wb_delay_slot_o  out  1  committed instruction was in a delay slot
- wb_flag_set_o, wb_flag_clear_o  out  1 each  flag updates
- wb_except_o  out  EXCEPT_WIDTH  exception vector
- wb_excepts_en_o  out  1  OR-reduction of wb_except_o

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): OCB pointers and count = 0, so ocb_empty_o=1 and ocb_full_o=0. Every registered wb_* output and pc_wb_o = 0.
- Push: push = dcod_valid_i & ~ocb_full_o & ~pipeline_flush_i. Uses the registered full only; an issue while full is dropped and the OCB is unchanged. Entry = {unit, rfd_adr, rf_wb, pc, delay_slot}.
- Head: h = unit field of the head entry. commit = ~ocb_empty_o & unit_rdy_i[h] & ~wb_stall_i & ~pipeline_flush_i.
- unit_taken_o: combinational, equals onehot(h) when commit, else all zero. A unit drops rdy the cycle after it is taken.
- No bypass: an entry must sit in the OCB at least one cycle. Issue in cycle N; earliest commit is cycle N+1; wb outputs are valid in cycle N+2.
- Simultaneous push and pop:
  - Allowed whenever not full; count is unchanged.
  - When empty, the push is stored and no pop occurs.
  - When full, the pop proceeds and the push is dropped.
- Pointers wrap modulo OCB_DEPTH. Count width is clog2(OCB_DEPTH)+1. full = (count == OCB_DEPTH); empty = (count == 0).
- On commit, registered at the edge:
  - wb_valid_o = 1.
  - wb_rfd_adr_o, pc_wb_o and wb_delay_slot_o come from the head entry.
  - The result register takes unit_result_i slice h.
  - wb_flag_set_o and wb_flag_clear_o come from unit bit h.
  - wb_except_o = unit_except_i slice h.
  - wb_rf_wb_o = entry.rf_wb & ~|except (an exception suppresses the RF write).
- On a non-commit cycle:
  - wb_valid_o, wb_rf_wb_o, the flag outputs, wb_except_o and wb_excepts_en_o go to 0 (pulse semantics).
  - wb_rfd_adr_o, pc_wb_o, the result register and wb_delay_slot_o hold their values.
- wb_result_o = ctrl_mfspr_rdy_i ? mfspr_dat_i : result register. This path is combinational.
- Flush (pipeline_flush_i=1):
  - At the edge, OCB count and pointers go to 0.
  - All pulse outputs and wb_delay_slot_o go to 0.
  - During the flush cycle, push and commit are both suppressed and unit_taken_o = 0.
  - Rising-edge precedence: rst, then flush, then commit/push.
- dcod_unit_i >= NUM_UNITS is illegal. Such an entry never commits; the bench asserts it never occurs.

Decomposition:
- Shared package mor1kx_marocchino_pkg:
  - UID_W, OCB_PTR_W and OCB_CNT_W localparams.
  - OCB entry field offsets and width.
  - Exception bit indices (ibus_err..dbus_align).
- Sub-module mor1kx_ocb_marocchino: synchronous FIFO of OCB entries with push, pop, flush, full and empty, parametrised by depth and entry width.
- The top-level module holds head decode, commit logic, output registers and the MFSPR mux.

Test Plan:
- Reset, then issue unit 2, rd=r5, pc=0x100, with unit_rdy_i[2] in the next cycle and result 0xDEADBEEF → one cycle later wb_valid_o=1, wb_rf_wb_o=1, wb_rfd_adr_o=5, pc_wb_o=0x100, wb_result_o=0xDEADBEEF, unit_taken_o=4'b0100 in the commit cycle.
- Out-of-order completion: issue unit1 (pc 0x10), then unit0 (pc 0x14); unit0 ready first, unit1 ready 3 cycles later → commits occur in the order 0x10 then 0x14, and unit0 receives no taken until unit1 commits.
- Full/wrap: issue 4 without completions → ocb_full_o=1 and a 5th issue is dropped. Then drain and refill 6 entries → PCs commit in order across the pointer wrap and ocb_empty_o=1 at the end.
- Exception: head unit3 with except vector 11'h004 and rf_wb=1 → wb_except_o=11'h004, wb_excepts_en_o=1, wb_rf_wb_o=0.
- Flush with 3 entries, asserted in the same cycle as a unit_rdy_i for the head and a new issue → no commit, unit_taken_o=0; next cycle ocb_empty_o=1 and all pulse outputs are 0.
- wb_stall_i held for 2 cycles with the head ready → no commit; commit occurs in the first unstalled cycle. With ctrl_mfspr_rdy_i=1 and mfspr_dat_i=0x55 → wb_result_o=0x55 combinationally.
